press_classifier: RTL and testbench
===================================

# press_classifier

Front-end for a single push-button. It synchronises and debounces the raw pin, times how long the button is held, and classifies each press as a one-cycle `short_press` or `long_press` pulse for the control logic downstream. It drives a hold-duration timer sub-module through the usual `enable`/`reset_sync`/`done` handshake. It sits between the board pin and the application FSM.

## Interface
Parameters:
- `CLK_PERIOD_ns`, 20: clock period.
- `DEBOUNCE_ns`, 10_000_000: stability window. `DEB_COUNT = DEBOUNCE_ns/CLK_PERIOD_ns`, must be ≥1.
- `LONG_PRESS_ns`, 1_000_000_000: long-press threshold. `LONG_COUNT = LONG_PRESS_ns/CLK_PERIOD_ns`, must be ≥2.
- `BTN_ACTIVE_LOW`, 1: pin polarity. 1 means pressed = 0.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: asynchronous, active-low reset.
- `btn_in` in 1: raw button pin, asynchronous to `clk`.
- `held` out 1: debounced pressed level, active-high, registered.
- `short_press` out 1: one-cycle pulse, registered.
- `long_press` out 1: one-cycle pulse, registered.

## Operation
- Reset values, applied asynchronously while `resetn`=0:
  - Synchroniser flops load the released pin level.
  - Debounce counter = 0.
  - `held`, `short_press`, `long_press` = 0.
  - FSM = IDLE.
  - Timer is cleared.
- Synchroniser: 2 flops on `btn_in`, then polarity normalisation, giving `btn_s`.
- Debouncer:
  - Counter increments each cycle `btn_s` ≠ `held`.
  - Counter clears to 0 on any cycle `btn_s` = `held`, so any bounce restarts the window.
  - When the counter reaches `DEB_COUNT`, `held` toggles and the counter clears.
  - Counter width is `$clog2(DEB_COUNT+1)` and it never wraps.
- FSM, states IDLE, PRESSED, LONG_HELD:
  - IDLE: `held` rising → PRESSED.
  - PRESSED:
    - Timer `enable`=1.
    - `held` falling before `done` → `short_press`=1 next cycle, → IDLE.
    - `done` while still held → `long_press`=1 next cycle, → LONG_HELD.
  - LONG_HELD: wait for `held` falling → IDLE, no pulse. Holding longer never re-fires.
  - Simultaneous `held` falling and `done` in PRESSED: release wins, so `short_press` fires.
- Timer handshake:
  - `enable`=1 only in PRESSED.
  - `reset_sync` is pulsed on every entry to PRESSED.
  - `done` is sticky until `reset_sync` or `enable`=0.
- At most one of `short_press`/`long_press` fires per press. They are never both high.
- Reset mid-press: no pulse is emitted. A button still held at reset release is treated as a new press after the debounce latency.

## Timing
- Press/release latency:
  - Take edge 0 as the first `clk` edge sampling the new pin level, with the pin stable from then on.
  - `btn_s` changes after edge 2.
  - `held` changes after edge `2+DEB_COUNT`.
- Long press:
  - `long_press` is high exactly `LONG_COUNT` cycles after `held` rises, provided the button is not released.
  - The pulse lasts exactly 1 cycle.
- Short press: `short_press` is high the cycle after `held` falls, for 1 cycle.
- Press duration is measured in debounced cycles. A press of exactly `LONG_COUNT-1` held cycles is short.
- Minimum gap between consecutive presses is 2×`DEB_COUNT`+2 cycles. No press is lost at that rate.

## Structure
- Package `press_pkg` holds:
  - the state enum `press_state_t` (IDLE, PRESSED, LONG_HELD);
  - a function computing cycle counts from ns parameters;
  - the `$clog2` width helper.
- One sub-module, `hold_timer`:
  - a down-counter loaded with `LONG_COUNT-1`;
  - inputs `enable`, `reset_sync`;
  - sticky `done` at 0;
  - async active-low reset on `resetn`.
- Debouncer and synchroniser stay inline. Parameter checks on `DEB_COUNT`/`LONG_COUNT` run at elaboration.

## Test plan
All scenarios use `CLK_PERIOD_ns`=20, `DEBOUNCE_ns`=100 (`DEB_COUNT`=5), `LONG_PRESS_ns`=400 (`LONG_COUNT`=20), `BTN_ACTIVE_LOW`=1.
- Reset: `resetn`=0 with `btn_in`=1 → all outputs 0. `btn_in`=0 held through reset release → `held` rises 7 cycles later and no pulse follows reset.
- Short press: pin low for 12 cycles, then high → `held` high for 12 cycles, `short_press`=1 for one cycle after `held` falls, `long_press` stays 0.
- Long press: pin low for 60 cycles → `long_press`=1 exactly 20 cycles after `held` rises, once only. Release → no `short_press`.
- Bounce: pin toggles every 3 cycles for 30 cycles, then stays high → `held` never rises and no pulses. Toggling every 3 cycles and then stable low → `held` rises 7 cycles after the last edge.
- Boundary: press lasting 19 debounced cycles → `short_press`. Press lasting 20 cycles with release coincident with `done` → `short_press`, no `long_press`.
- Reset mid-press: `resetn` asserted 10 cycles into a long press → both pulses stay 0 and FSM = IDLE. Two back-to-back short presses at the minimum gap → two `short_press` pulses.

Source files
------------

// File: rtl/press_pkg.sv
// Shared types and elaboration helpers for the push-button front-end.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } press_state_t;

    // Whole clock cycles that fit in a duration given in ns.
    function automatic int unsigned ns_to_cycles(input int unsigned t_ns, input int unsigned period_ns);
        return t_ns / period_ns;
    endfunction

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/press_classifier_hold_timer.sv
// Hold-duration down-counter; done goes high and stays high once the count reaches 0.
module hold_timer
    import press_pkg::*;
#(
    parameter int unsigned LONG_COUNT = 20
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic reset_sync,
    output logic done
);

    localparam int unsigned CW = cnt_width(LONG_COUNT - 1);

    logic [CW-1:0] count;

    // Reload whenever the timer is idle so the next enable starts a full interval.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= CW'(LONG_COUNT - 1);
            done  <= 1'b0;
        end else if (reset_sync || !enable) begin
            count <= CW'(LONG_COUNT - 1);
            done  <= 1'b0;
        end else if (count != '0) begin
            count <= count - CW'(1);
            done  <= (count == CW'(1));
        end
    end

endmodule

// File: rtl/press_classifier.sv
// Push-button front-end: synchronise, debounce, and classify each press as short or long.
module press_classifier
    import press_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_ns  = 20,
    parameter int unsigned DEBOUNCE_ns    = 10_000_000,
    parameter int unsigned LONG_PRESS_ns  = 1_000_000_000,
    parameter int unsigned BTN_ACTIVE_LOW = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_in,
    output logic held,
    output logic short_press,
    output logic long_press
);

    localparam int unsigned DEB_COUNT  = ns_to_cycles(DEBOUNCE_ns, CLK_PERIOD_ns);
    localparam int unsigned LONG_COUNT = ns_to_cycles(LONG_PRESS_ns, CLK_PERIOD_ns);
    localparam int unsigned DEB_W      = cnt_width(DEB_COUNT);
    localparam logic        RELEASED   = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (DEB_COUNT < 1) begin : g_deb_chk
        $error("press_classifier: DEB_COUNT must be >= 1");
    end
    if (LONG_COUNT < 2) begin : g_long_chk
        $error("press_classifier: LONG_COUNT must be >= 2");
    end

    logic [1:0]       sync_q;
    logic             btn_s;
    logic [DEB_W-1:0] deb_cnt;
    logic             toggle_c;
    logic             rise_c;
    logic             fall_c;

    press_state_t state, state_d;
    logic         short_d, long_d;
    logic         timer_en_c, timer_rst_c, timer_done;

    // The last window cycle toggles held directly, so held moves DEB_COUNT cycles after btn_s.
    assign toggle_c = (btn_s != held) && (deb_cnt == DEB_W'(DEB_COUNT - 1));
    assign rise_c   = toggle_c && !held;
    assign fall_c   = toggle_c && held;

    // Synchroniser, polarity normalisation and debounce window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= {2{RELEASED}};
            btn_s   <= 1'b0;
            deb_cnt <= '0;
            held    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_in};
            btn_s  <= sync_q[1] ^ RELEASED;
            if (toggle_c) begin
                held    <= ~held;
                deb_cnt <= '0;
            end else if (btn_s != held) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // FSM follows the debouncer's edge strobes so pulses line up with the held transitions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            state       <= state_d;
            short_press <= short_d;
            long_press  <= long_d;
        end
    end

    // Release takes priority over done so a coincident release still reads as short.
    always_comb begin
        state_d     = state;
        short_d     = 1'b0;
        long_d      = 1'b0;
        timer_en_c  = 1'b0;
        timer_rst_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise_c) begin
                    state_d     = PRESSED;
                    timer_rst_c = 1'b1;
                end
            end
            PRESSED: begin
                timer_en_c = 1'b1;
                if (fall_c) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end else if (timer_done) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    hold_timer #(
        .LONG_COUNT(LONG_COUNT)
    ) u_hold_timer (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (timer_en_c),
        .reset_sync(timer_rst_c),
        .done      (timer_done)
    );

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: expected held edges and pulses are queued per press.
module tb_press_classifier;
    import press_pkg::*;

    localparam int unsigned DEB  = 5;
    localparam int unsigned LONG = 20;
    localparam int unsigned LAT  = 2 + DEB + 1;   // pin set after edge p -> held moves at edge p+LAT

    localparam logic [7:0] EV_RISE  = 8'd1;
    localparam logic [7:0] EV_FALL  = 8'd2;
    localparam logic [7:0] EV_SHORT = 8'd3;
    localparam logic [7:0] EV_LONG  = 8'd4;

    typedef struct packed {
        logic [7:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic clk = 1'b0;
    logic resetn;
    logic btn_in;
    logic held, short_press, long_press;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_held = 1'b0;
    ev_t  exp_q[$];

    press_classifier #(
        .CLK_PERIOD_ns (20),
        .DEBOUNCE_ns   (100),
        .LONG_PRESS_ns (400),
        .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_in     (btn_in),
        .held       (held),
        .short_press(short_press),
        .long_press (long_press)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [7:0] kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = 32'(c);
        exp_q.push_back(e);
    endtask

    // Pin goes low just after edge p and stays low for n cycles.
    task automatic push_press(input int p, input int n);
        push_ev(EV_RISE, p + int'(LAT));
        if (n > int'(LONG)) begin
            push_ev(EV_LONG, p + int'(LAT) + int'(LONG));
            push_ev(EV_FALL, p + n + int'(LAT));
        end else begin
            push_ev(EV_FALL, p + n + int'(LAT));
            push_ev(EV_SHORT, p + n + int'(LAT));
        end
    endtask

    task automatic observe(input logic [7:0] kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_event", 32'(kind), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("event_kind", 32'(kind), 32'(e.kind));
            check_eq("event_cycle", 32'(cyc), e.cyc);
        end
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (resetn !== 1'b1) begin
            prev_held = 1'b0;
            check_eq("reset_outputs", {29'd0, held, short_press, long_press}, 32'd0);
        end else begin
            if (held && !prev_held) observe(EV_RISE);
            if (!held && prev_held) observe(EV_FALL);
            if (short_press) observe(EV_SHORT);
            if (long_press) observe(EV_LONG);
            check_eq("pulse_exclusive", 32'(short_press & long_press), 32'd0);
            prev_held = held;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_press(input int n_low, input int gap);
        push_press(cyc, n_low);
        btn_in = 1'b0;
        tick(n_low);
        btn_in = 1'b1;
        tick(gap);
    endtask

    initial begin
        int last;
        int p;

        resetn = 1'b0;
        btn_in = 1'b1;
        tick(3);
        check_eq("reset_held", 32'(held), 32'd0);
        check_eq("reset_state", 32'(dut.state), 32'(IDLE));
        resetn = 1'b1;
        tick(10);

        // Short, long and boundary presses.
        do_press(12, 20);
        do_press(60, 20);
        do_press(19, 20);
        do_press(20, 20);
        do_press(21, 20);

        // Bounce that settles released: nothing expected.
        for (int k = 0; k < 10; k++) begin
            btn_in = ~btn_in;
            tick(3);
        end
        tick(20);

        // Bounce that settles pressed.
        last = 0;
        for (int k = 0; k < 9; k++) begin
            btn_in = ~btn_in;
            last = cyc;
            tick(3);
        end
        push_press(last, 15);
        tick(12);
        btn_in = 1'b1;
        tick(20);

        // Button held through reset release counts as a fresh press.
        resetn = 1'b0;
        btn_in = 1'b0;
        tick(3);
        resetn = 1'b1;
        push_press(cyc, 15);
        tick(15);
        btn_in = 1'b1;
        tick(20);

        // Reset ten cycles into a long press: only the rise is expected.
        p = cyc;
        push_ev(EV_RISE, p + int'(LAT));
        btn_in = 1'b0;
        tick(int'(LAT) + 10);
        resetn = 1'b0;
        tick(2);
        check_eq("midpress_state", 32'(dut.state), 32'(IDLE));
        check_eq("midpress_pulses", {30'd0, short_press, long_press}, 32'd0);
        btn_in = 1'b1;
        tick(2);
        resetn = 1'b1;
        tick(30);

        // Two short presses at the minimum gap.
        do_press(8, 2 * int'(DEB) + 2);
        do_press(8, 30);

        tick(40);
        check_eq("pending_events", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
